halflife_ctrl: RTL and testbench

Sequencing controller for the half-life timer datapath. It loads an initial quantity and a half-life period in clock cycles, then halves the quantity once per period until it falls to or below a threshold. It emits a tick strobe per halving and a done strobe at the end. It sits above the 4-bit half-life counter and drives the decay schedule that the counter displays.

---
 rtl/halflife_pkg.sv | 18 +
 rtl/halflife_timer.sv | 40 ++++
 rtl/halflife_ctrl.sv | 134 +++++++++++++
 tb/tb_halflife_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halflife_pkg.sv
// Shared types and default widths for the half-life sequencing controller.
// Optional run-pause input is enabled by defining HALFLIFE_PAUSE_EN.
package halflife_pkg;

    localparam int QW_DEF = 8;
    localparam int PW_DEF = 16;
    localparam int HW_DEF = 4;

    // Value at which the halvings counter stops counting.
    localparam int unsigned HALV_SAT = (1 << HW_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/halflife_timer.sv
// Reloadable down-counter for the half-life period; load has priority over count.
// Used by halflife_ctrl (optional pause via HALFLIFE_PAUSE_EN lives in the top).
module halflife_timer
    import halflife_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [PW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/halflife_ctrl.sv
// Half-life decay sequencer: halves qty once per latched period until qty <= min.
// Define HALFLIFE_PAUSE_EN to add a pause input that freezes the run.
module halflife_ctrl
    import halflife_pkg::*;
#(
    parameter int QW = QW_DEF,
    parameter int PW = PW_DEF,
    parameter int HW = HW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
`ifdef HALFLIFE_PAUSE_EN
    input  logic          pause,
`endif
    input  logic [QW-1:0] init_qty,
    input  logic [PW-1:0] period,
    input  logic [QW-1:0] min_qty,
    output logic [QW-1:0] qty,
    output logic [HW-1:0] halvings,
    output logic          busy,
    output logic          tick,
    output logic          done
);

    localparam logic [HW-1:0] HSAT = '1;

    state_t        state_q;
    logic [PW-1:0] per_q;
    logic [QW-1:0] min_q;
    logic [QW-1:0] qty_q;
    logic [HW-1:0] halv_q;
    logic          busy_q;
    logic          tick_q;
    logic          done_q;

    logic          pause_act;
    logic          accept;
    logic          run_go;
    logic          step;
    logic          tmr_zero;
    logic          tmr_load;
    logic [PW-1:0] tmr_load_val;
    logic [PW-1:0] per_in;
    logic [QW-1:0] half;

`ifdef HALFLIFE_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    // A zero period behaves as one cycle per halving.
    assign per_in       = (period == '0) ? PW'(1) : period;
    assign accept       = (state_q == IDLE) && start && !abort;
    assign run_go       = (state_q == RUN) && !abort && !pause_act;
    assign step         = run_go && tmr_zero;
    assign half         = qty_q >> 1;
    assign tmr_load     = accept || step;
    assign tmr_load_val = accept ? (per_in - PW'(1)) : (per_q - PW'(1));

    halflife_timer #(.PW(PW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (run_go),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            per_q   <= '0;
            min_q   <= '0;
            qty_q   <= '0;
            halv_q  <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        qty_q  <= init_qty;
                        halv_q <= '0;
                        per_q  <= per_in;
                        min_q  <= min_qty;
                        if (init_qty <= min_qty) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (step) begin
                        qty_q  <= half;
                        halv_q <= (halv_q == HSAT) ? halv_q : halv_q + HW'(1);
                        tick_q <= 1'b1;
                        // qty of 0 always ends the run since 0 <= any threshold.
                        if (half <= min_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= !abort;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign qty      = qty_q;
    assign halvings = halv_q;
    assign busy     = busy_q;
    assign tick     = tick_q;
    assign done     = done_q;

endmodule

// File: tb/tb_halflife_ctrl.sv
// Self-checking bench for halflife_ctrl: directed scenarios plus randomized traffic
// against an absolute-cycle schedule model. Pause scenario runs under HALFLIFE_PAUSE_EN.
module tb_halflife_ctrl;

    localparam int QW = 8;
    localparam int PW = 16;
    localparam int HW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pause = 1'b0;
    logic [QW-1:0] init_qty = '0;
    logic [PW-1:0] period = '0;
    logic [QW-1:0] min_qty = '0;
    logic [QW-1:0] qty;
    logic [HW-1:0] halvings;
    logic          busy;
    logic          tick;
    logic          done;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    halflife_ctrl #(.QW(QW), .PW(PW), .HW(HW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
`ifdef HALFLIFE_PAUSE_EN
        .pause    (pause),
`endif
        .init_qty (init_qty),
        .period   (period),
        .min_qty  (min_qty),
        .qty      (qty),
        .halvings (halvings),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks the absolute edge number of the next scheduled halving.
    int cyc = 0;
    int m_mode = 0;          // 0 idle, 1 running, 2 finishing
    int next_upd = 0;
    int per_l = 0;
    int min_l = 0;
    int m_qty = 0;
    int m_halv = 0;
    bit m_busy = 0;
    bit m_tick = 0;
    bit m_done = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; per_l = 0; min_l = 0; m_qty = 0; m_halv = 0;
            m_busy = 0; m_tick = 0; m_done = 0;
        end else begin
            bit paused;
`ifdef HALFLIFE_PAUSE_EN
            paused = pause;
`else
            paused = 1'b0;
`endif
            cyc++;
            m_tick = 0;
            m_done = 0;
            if (m_mode == 0) begin
                if (start && !abort) begin
                    per_l    = (period == 0) ? 1 : int'(period);
                    min_l    = int'(min_qty);
                    m_qty    = int'(init_qty);
                    m_halv   = 0;
                    next_upd = cyc + per_l;
                    m_mode   = (m_qty <= min_l) ? 2 : 1;
                end
            end else if (m_mode == 1) begin
                if (abort) begin
                    m_mode = 0;
                end else if (paused) begin
                    next_upd++;
                end else if (cyc == next_upd) begin
                    m_qty    = m_qty / 2;
                    m_halv   = (m_halv + 1 > 15) ? 15 : m_halv + 1;
                    m_tick   = 1;
                    next_upd = next_upd + per_l;
                    if (m_qty <= min_l) m_mode = 2;
                end
            end else begin
                m_done = !abort;
                m_mode = 0;
            end
            m_busy = (m_mode == 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("qty", int'(qty), m_qty);
            check("halvings", int'(halvings), m_halv);
            check("busy", int'(busy), int'(m_busy));
            check("tick", int'(tick), int'(m_tick));
            check("done", int'(done), int'(m_done));
        end
    end

    // Event log used by the literal checks.
    int tq[$];
    int tc[$];
    int dc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (tick === 1'b1) begin
                tq.push_back(int'(qty));
                tc.push_back(cyc);
            end
            if (done === 1'b1) dc.push_back(cyc);
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_qty"}, int'(qty), 0);
        check({tag, "_halv"}, int'(halvings), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_tick"}, int'(tick), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic do_start(input int iq, input int p, input int mq, output int k);
        repeat (2) @(negedge clk);
        tq.delete(); tc.delete(); dc.delete();
        init_qty = QW'(iq); period = PW'(p); min_qty = QW'(mq); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (dc.size() == 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, dc.size(), 1);
    endtask

    initial begin
        int k;
        int exp_q[5];
        int n;

        // Reset applied between edges with garbage inputs.
        init_qty = 8'hA5; period = 16'h1234; min_qty = 8'h3C; start = 1'b1; abort = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("rst0");
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Normal run.
        exp_q = '{100, 50, 25, 12, 6};
        do_start(200, 4, 10, k);
        wait_done("norm", 40);
        check("norm_nticks", tq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < tq.size()) begin
                check($sformatf("norm_tq%0d", i), tq[i], exp_q[i]);
                check($sformatf("norm_tc%0d", i), tc[i] - k, 4 * (i + 1));
            end
        end
        if (dc.size() > 0) check("norm_done_at", dc[0] - k, 21);
        @(negedge clk);
        check("norm_halv", int'(halvings), 5);
        check("norm_qty", int'(qty), 6);
        check("norm_busy", int'(busy), 0);

        // Period zero: one halving per edge down to 0.
        do_start(8, 0, 0, k);
        wait_done("p0", 20);
        check("p0_nticks", tq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < tq.size()) begin
                check($sformatf("p0_tq%0d", i), tq[i], 8 >> (i + 1));
                check($sformatf("p0_tc%0d", i), tc[i] - k, i + 1);
            end
        end
        if (dc.size() > 0) check("p0_done_at", dc[0] - k, 5);
        check("p0_halv", int'(halvings), 4);

        // Immediate completion.
        do_start(5, 7, 5, k);
        wait_done("imm", 10);
        check("imm_nticks", tq.size(), 0);
        if (dc.size() > 0) check("imm_done_at", dc[0] - k, 1);
        check("imm_qty", int'(qty), 5);
        check("imm_halv", int'(halvings), 0);

        // Abort after second tick; start in RUN ignored.
        do_start(64, 3, 0, k);
        @(negedge clk);
        init_qty = 8'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (tq.size() < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_two_ticks", tq.size(), 2);
        if (tq.size() > 0) check("abort_tq0", tq[0], 32);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_qty", int'(qty), 16);
        check("abort_halv", int'(halvings), 2);
        check("abort_busy", int'(busy), 0);
        check("abort_no_done", dc.size(), 0);
        check("abort_nticks", tq.size(), 2);
        init_qty = 8'd77; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("sa_busy", int'(busy), 0);
        check("sa_qty", int'(qty), 16);

        // Mid-run async reset clears a live tick immediately.
        do_start(200, 2, 0, k);
        n = 0;
        while (tick !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("mr_tick_seen", int'(tick), 1);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;

`ifdef HALFLIFE_PAUSE_EN
        do_start(200, 4, 10, k);
        n = 0;
        while (tq.size() < 1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        pause = 1'b1;
        repeat (5) @(negedge clk);
        pause = 1'b0;
        wait_done("pause", 60);
        check("pause_nticks", tq.size(), 5);
        if (tq.size() == 5) begin
            check("pause_gap0", tc[0] - k, 4);
            check("pause_gap1", tc[1] - tc[0], 9);
            check("pause_gap2", tc[2] - tc[1], 4);
            check("pause_gap3", tc[3] - tc[2], 4);
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 5) == 0);
            abort    = ($urandom_range(0, 49) == 0);
            pause    = ($urandom_range(0, 3) == 0);
            init_qty = QW'($urandom);
            period   = PW'($urandom_range(0, 5));
            min_qty  = QW'($urandom_range(0, 63));
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b1;
                #1 check_zero("rst_rand");
                @(negedge clk);
                rst = 1'b0;
            end
        end
        start = 1'b0; abort = 1'b0; pause = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
